// File: rtl/md_pkg.sv
// Shared encodings for the iterative multiply/divide unit (mult_div_seq).
package md_pkg;

    localparam int MD_OP_W    = 2;
    localparam int MD_STATE_W = 2;

    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [MD_STATE_W-1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_sign_unit.sv
// Sign handling for mult_div_seq: operand magnitudes at start and
// conditional two's-complement negation of results before writeback.
module md_sign_unit #(
    parameter int WIDTH = 32
) (
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   a_mag,
    output logic [WIDTH-1:0]   b_mag,
    output logic               a_neg,
    output logic               b_neg,
    input  logic [2*WIDTH-1:0] prod,
    input  logic               prod_neg,
    output logic [2*WIDTH-1:0] prod_fix,
    input  logic [WIDTH-1:0]   quo,
    input  logic               quo_neg,
    output logic [WIDTH-1:0]   quo_fix,
    input  logic [WIDTH-1:0]   rem,
    input  logic               rem_neg,
    output logic [WIDTH-1:0]   rem_fix
);

    // Operand magnitudes; unsigned ops pass the raw bits through.
    // The most negative value maps onto itself, which is its correct
    // unsigned magnitude.
    always_comb begin
        a_neg = signed_op & a[WIDTH-1];
        b_neg = signed_op & b[WIDTH-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    // Result sign correction.
    always_comb begin
        prod_fix = prod_neg ? (~prod + 1'b1) : prod;
        quo_fix  = quo_neg  ? (~quo  + 1'b1) : quo;
        rem_fix  = rem_neg  ? (~rem  + 1'b1) : rem;
    end

endmodule

// File: rtl/mult_div_seq.sv
// Iterative radix-2 multiply/divide unit with start/busy/done handshake.
// Optional build macro: MD_EARLY_TERM_EN (multiply leaves CALC as soon as
// the remaining multiplier bits are all zero).
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   MD_IDLE | waiting for start; hi/lo hold the last result
//   MD_CALC | one shift-add / shift-subtract step per cycle
//   MD_FIX  | sign correction and hi/lo writeback
module mult_div_seq
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    md_state_e          state, state_nxt;
    md_op_e             op_q;
    logic [2*WIDTH-1:0] opa_sh;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               neg_p;
    logic               neg_r;

    logic               accept;
    logic               dz_start;
    logic               early_done;
    logic               cnt_last;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               a_neg, b_neg;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    logic [2*WIDTH-1:0] mul_acc_nxt;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_borrow;
    logic [WIDTH-1:0]   div_rem_nxt;
    logic [2*WIDTH-1:0] div_acc_nxt;

    md_sign_unit #(
        .WIDTH (WIDTH)
    ) u_sign (
        .signed_op (~op[0]),
        .a         (a),
        .b         (b),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .prod      (acc),
        .prod_neg  (neg_p),
        .prod_fix  (prod_fix),
        .quo       (acc[WIDTH-1:0]),
        .quo_neg   (neg_p),
        .quo_fix   (quo_fix),
        .rem       (acc[2*WIDTH-1:WIDTH]),
        .rem_neg   (neg_r),
        .rem_fix   (rem_fix)
    );

    assign busy     = (state != MD_IDLE);
    assign cnt_last = (cnt == CNT_W'(1));

`ifdef MD_EARLY_TERM_EN
    assign early_done = ~op_q[1] && (opb[WIDTH-1:1] == '0);
`else
    assign early_done = 1'b0;
`endif

    // One radix-2 step: multiply adds the shifted multiplicand into the
    // accumulator; divide shifts the next dividend bit into the partial
    // remainder and keeps the difference only when it does not borrow.
    always_comb begin
        mul_acc_nxt = acc + (opb[0] ? opa_sh : '0);
        div_shift   = {acc[2*WIDTH-1:WIDTH], opa_sh[WIDTH-1]};
        div_diff    = {1'b0, div_shift} - {2'b00, opb};
        div_borrow  = div_diff[WIDTH+1];
        div_rem_nxt = div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        div_acc_nxt = {div_rem_nxt, acc[WIDTH-2:0], ~div_borrow};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and start qualification.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        dz_start  = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    if (op[1] && (b == '0)) begin
                        dz_start = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                if (cnt_last || early_done) begin
                    state_nxt = MD_FIX;
                end
            end
            MD_FIX:  state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    // Datapath, iteration counter and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= MD_MULT;
            opa_sh   <= '0;
            opb      <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg_p    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op_q     <= md_op_e'(op);
                opa_sh   <= {{WIDTH{1'b0}}, a_mag};
                opb      <= b_mag;
                acc      <= '0;
                cnt      <= CNT_W'(WIDTH);
                neg_p    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= 1'b0;
            end else if (dz_start) begin
                done     <= 1'b1;
                div_zero <= 1'b1;
            end else if (state == MD_CALC) begin
                cnt    <= cnt - 1'b1;
                opa_sh <= opa_sh << 1;
                if (op_q[1]) begin
                    acc <= div_acc_nxt;
                end else begin
                    acc <= mul_acc_nxt;
                    opb <= opb >> 1;
                end
            end else if (state == MD_FIX) begin
                done <= 1'b1;
                if (op_q[1]) begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end else begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed self-checking bench for mult_div_seq (WIDTH = 32).
module tb_mult_div_seq;
    import md_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] hi, lo;
    logic         busy, done, div_zero;

    int n_cmp = 0;
    int n_mis = 0;

    int done_cyc, busy_cyc, done_seen;
    bit overlap;

    mult_div_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a start from a #1-after-edge point in an IDLE cycle (cycle 0)
    // and follow the operation until done, with a cycle budget.
    // With inject set, start is pulsed with other operands in cycles 5 and 20.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit inject, output int dcyc, output int bcyc, output bit ovl);
        int cyc;
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        cyc  = 1;
        dcyc = -1;
        bcyc = 0;
        ovl  = 1'b0;
        while (cyc <= 100) begin
            if (busy) bcyc++;
            if (busy && done) ovl = 1'b1;
            if (done) begin
                dcyc = cyc;
                break;
            end
            if (inject && (cyc == 5 || cyc == 20)) begin
                start = 1'b1; op = MD_DIVU; a = 32'hDEAD_BEEF; b = 32'h0000_0003;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = MD_MULT; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div_zero", div_zero, 0);
        reset = 1'b0;
        tick();

        // Signed multiply with full-latency timing.
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, done_cyc, busy_cyc, overlap);
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFEB);
`ifdef MD_EARLY_TERM_EN
        check("mult_neg_done_cyc", 64'(done_cyc), 5);
        check("mult_neg_busy_cycles", 64'(busy_cyc), 4);
`else
        check("mult_neg_done_cyc", 64'(done_cyc), 34);
        check("mult_neg_busy_cycles", 64'(busy_cyc), 33);
`endif
        check("mult_neg_busy_done_overlap", overlap, 0);
        tick();
        check("idle_after_done", done, 0);

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, done_cyc, busy_cyc, overlap);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);
        tick();
        run_op(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, done_cyc, busy_cyc, overlap);
        check("mult_m1_hi", hi, 32'h0);
        check("mult_m1_lo", lo, 32'h1);
        tick();

        // Divides.
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, done_cyc, busy_cyc, overlap);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);
        check("div_done_cyc", 64'(done_cyc), 34);
        tick();
        run_op(MD_DIVU, 32'd100, 32'd7, 1'b0, done_cyc, busy_cyc, overlap);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);
        tick();
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, done_cyc, busy_cyc, overlap);
        check("div_min_lo", lo, 32'h8000_0000);
        check("div_min_hi", hi, 32'h0);
        check("div_min_flag", div_zero, 0);
        tick();

        // Divide by zero after a result of hi=5, lo=9.
        run_op(MD_DIVU, 32'd68, 32'd7, 1'b0, done_cyc, busy_cyc, overlap);
        check("pre_dz_hi", hi, 32'd5);
        check("pre_dz_lo", lo, 32'd9);
        tick();
        run_op(MD_DIV, 32'd1234, 32'd0, 1'b0, done_cyc, busy_cyc, overlap);
        check("dz_done_cyc", 64'(done_cyc), 1);
        check("dz_flag_cyc1", div_zero, 1);
        check("dz_busy_cycles", 64'(busy_cyc), 0);
        check("dz_hi_kept", hi, 32'd5);
        check("dz_lo_kept", lo, 32'd9);
        tick();
        check("dz_done_cleared", done, 0);
        check("dz_busy_cyc2", busy, 0);
        tick();
        check("dz_flag_sticky", div_zero, 1);
        op = MD_MULTU; a = 32'd2; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check("dz_cleared_on_start", div_zero, 0);
        check("dz_next_busy", busy, 1);
        repeat (40) begin
            if (done) break;
            tick();
        end
        check("post_dz_lo", lo, 32'd6);
        tick();

        // Starts during a multiply are ignored; start in the done cycle is taken.
        run_op(MD_MULT, 32'h1234_5678, 32'h0000_0010, 1'b1, done_cyc, busy_cyc, overlap);
        check("ign_hi", hi, 32'h0000_0001);
        check("ign_lo", lo, 32'h2345_6780);
        run_op(MD_MULTU, 32'd3, 32'd5, 1'b0, done_cyc, busy_cyc, overlap);
        check("b2b_lo", lo, 32'd15);
        check("b2b_hi", hi, 32'd0);
`ifndef MD_EARLY_TERM_EN
        check("b2b_done_cyc", 64'(done_cyc), 34);
`endif
        tick();

        // Reset in cycle 10 of a divide.
        op = MD_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("rst_mid_busy_before", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_hi", hi, 0);
        check("rst_mid_lo", lo, 0);
        check("rst_mid_done", done, 0);
        done_seen = 0;
        repeat (40) begin
            if (done) done_seen++;
            tick();
        end
        check("rst_mid_no_done", 64'(done_seen), 0);

`ifdef MD_EARLY_TERM_EN
        run_op(MD_MULT, 32'h0000_1234, 32'd1, 1'b0, done_cyc, busy_cyc, overlap);
        check("et_done_cyc", 64'(done_cyc), 3);
        check("et_lo", lo, 32'h0000_1234);
        check("et_hi", hi, 32'h0);
`else
        run_op(MD_MULT, 32'h0000_1234, 32'd0, 1'b0, done_cyc, busy_cyc, overlap);
        check("mul_zero_done_cyc", 64'(done_cyc), 34);
        check("mul_zero_lo", lo, 32'h0);
        check("mul_zero_hi", hi, 32'h0);
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
